// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared encodings for the RV32I multi-cycle control FSM
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERR    = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_CMP   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // One-hot instruction class; all-zero means the opcode is not supported.
  typedef struct packed {
    logic r;
    logic imm;
    logic load;
    logic store;
    logic branch;
  } inst_class_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - control FSM <-> datapath/memory signal bundle
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      inst;
  logic             br_taken;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             mem_addr_sel;
  logic             ir_we;
  logic             pc_we;
  logic             pc_src;
  logic             alu_src_b;
  logic [1:0]       alu_op;
  logic             reg_we;
  logic             wb_sel;
  logic             illegal_inst;
  logic             mem_err;
  logic [2:0]       state;
  logic [CNT_W-1:0] instret;

  modport master (
    input  inst, br_taken, mem_ready,
    output mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, alu_src_b,
           alu_op, reg_we, wb_sel, illegal_inst, mem_err, state, instret
  );

  modport slave (
    output inst, br_taken, mem_ready,
    input  mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, alu_src_b,
           alu_op, reg_we, wb_sel, illegal_inst, mem_err, state, instret
  );
endinterface

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - opcode to one-hot instruction class decoder
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [6:0]  opcode_i,
  output inst_class_t cls_o,
  output logic        illegal_o
);

  always_comb begin
    cls_o = '0;
    case (opcode_i)
      OP_R:      cls_o.r      = 1'b1;
      OP_IMM:    cls_o.imm    = 1'b1;
      OP_LOAD:   cls_o.load   = 1'b1;
      OP_STORE:  cls_o.store  = 1'b1;
      OP_BRANCH: cls_o.branch = 1'b1;
      default:   cls_o        = '0;
    endcase
    illegal_o = (cls_o == '0);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - RV32I multi-cycle control FSM with memory timeout
// Optional ILLEGAL_TRAP_EN: illegal opcodes halt in TRAP instead of acting as NOP.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 16,
  parameter int CNT_W        = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  multicycle_ctrl_if.master  bus
);

  localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  instret_q;
  logic              retire;
  logic              timeout;
  inst_class_t       cls;
  logic              illegal;

  logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, alu_src_b;
  logic [1:0] alu_op;
  logic       reg_we, wb_sel, illegal_inst, mem_err;

  ctrl_decode u_decode (
    .opcode_i  (bus.inst[6:0]),
    .cls_o     (cls),
    .illegal_o (illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign timeout = !bus.mem_ready && (wait_q == WAIT_LAST);

  always_comb begin
    state_d      = state_q;
    retire       = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 1'b0;
    alu_src_b    = 1'b0;
    alu_op       = ALU_ADD;
    reg_we       = 1'b0;
    wb_sel       = 1'b0;
    illegal_inst = 1'b0;
    mem_err      = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_ERR;
        end
      end
      S_DECODE: begin
        if (illegal) begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          pc_we   = 1'b1;
          state_d = S_FETCH;
`endif
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cls.r) begin
          alu_op  = ALU_FUNCT;
          state_d = S_WB;
        end else if (cls.imm) begin
          alu_src_b = 1'b1;
          alu_op    = ALU_FUNCT;
          state_d   = S_WB;
        end else if (cls.load || cls.store) begin
          alu_src_b = 1'b1;
          state_d   = S_MEM;
        end else if (cls.branch) begin
          alu_op  = ALU_CMP;
          pc_we   = 1'b1;
          pc_src  = bus.br_taken;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        // Address/operand selects held for the whole transfer so mem_addr is stable.
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = cls.store;
        alu_src_b    = 1'b1;
        if (bus.mem_ready) begin
          if (cls.store) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout) begin
          state_d = S_ERR;
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        wb_sel  = cls.load;
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_ERR: mem_err = 1'b1;
      S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        illegal_inst = 1'b1;
`else
        state_d = S_IDLE;
`endif
      end
    endcase
  end

  // Counter restarts on every state entry; only FETCH/MEM linger, and only while not ready.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if ((state_q == S_FETCH || state_q == S_MEM) && !bus.mem_ready) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  assign bus.mem_req      = mem_req;
  assign bus.mem_we       = mem_we;
  assign bus.mem_addr_sel = mem_addr_sel;
  assign bus.ir_we        = ir_we;
  assign bus.pc_we        = pc_we;
  assign bus.pc_src       = pc_src;
  assign bus.alu_src_b    = alu_src_b;
  assign bus.alu_op       = alu_op;
  assign bus.reg_we       = reg_we;
  assign bus.wb_sel       = wb_sel;
  assign bus.illegal_inst = illegal_inst;
  assign bus.mem_err      = mem_err;
  assign bus.state        = state_q;
  assign bus.instret      = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - table-driven bench for multicycle_ctrl (both ILLEGAL_TRAP_EN builds)
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic       pc_src;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic       reg_we;
    logic       wb_sel;
    logic       illegal_inst;
    logic       mem_err;
  } ctrl_t;

  typedef struct packed {
    logic [2:0] st;
    ctrl_t      c;
    logic [3:0] ir;
  } obs_t;

  typedef struct {
    logic        rst;
    logic [31:0] inst;
    logic        br;
    logic        rdy;
    obs_t        exp;
  } vec_t;

  localparam logic [31:0] I_R    = 32'h002081B3;
  localparam logic [31:0] I_ADDI = 32'h00108093;
  localparam logic [31:0] I_LD   = 32'h0080A283;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_ST   = 32'h0020A423;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  localparam ctrl_t C_NONE    = '0;
  localparam ctrl_t C_FETCH   = '{mem_req: 1'b1, default: '0};
  localparam ctrl_t C_FACK    = '{mem_req: 1'b1, ir_we: 1'b1, default: '0};
  localparam ctrl_t C_EX_R    = '{alu_op: 2'b10, default: '0};
  localparam ctrl_t C_EX_I    = '{alu_src_b: 1'b1, alu_op: 2'b10, default: '0};
  localparam ctrl_t C_EX_LS   = '{alu_src_b: 1'b1, default: '0};
  localparam ctrl_t C_BR_T    = '{alu_op: 2'b01, pc_we: 1'b1, pc_src: 1'b1, default: '0};
  localparam ctrl_t C_BR_N    = '{alu_op: 2'b01, pc_we: 1'b1, default: '0};
  localparam ctrl_t C_MEM_LD  = '{mem_req: 1'b1, mem_addr_sel: 1'b1, alu_src_b: 1'b1, default: '0};
  localparam ctrl_t C_MEM_ST  = '{mem_req: 1'b1, mem_we: 1'b1, mem_addr_sel: 1'b1, alu_src_b: 1'b1, default: '0};
  localparam ctrl_t C_ST_ACK  = '{mem_req: 1'b1, mem_we: 1'b1, mem_addr_sel: 1'b1, alu_src_b: 1'b1, pc_we: 1'b1, default: '0};
  localparam ctrl_t C_WB_ALU  = '{reg_we: 1'b1, pc_we: 1'b1, default: '0};
  localparam ctrl_t C_WB_LD   = '{reg_we: 1'b1, wb_sel: 1'b1, pc_we: 1'b1, default: '0};
  localparam ctrl_t C_PC      = '{pc_we: 1'b1, default: '0};
  localparam ctrl_t C_TRAP    = '{illegal_inst: 1'b1, default: '0};
  localparam ctrl_t C_ERR     = '{mem_err: 1'b1, default: '0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  vec_t tbl[$];
  obs_t exp_q[$];

  multicycle_ctrl_if #(.CNT_W(4)) bus ();

  multicycle_ctrl #(.MEM_WAIT_MAX(4), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [31:0] i, input logic b, input logic y,
                     input logic [2:0] s, input ctrl_t c, input logic [3:0] n);
    vec_t v;
    v.rst = r; v.inst = i; v.br = b; v.rdy = y;
    v.exp = '{st: s, c: c, ir: n};
    tbl.push_back(v);
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.st             = bus.state;
    o.ir             = bus.instret;
    o.c.mem_req      = bus.mem_req;
    o.c.mem_we       = bus.mem_we;
    o.c.mem_addr_sel = bus.mem_addr_sel;
    o.c.ir_we        = bus.ir_we;
    o.c.pc_we        = bus.pc_we;
    o.c.pc_src       = bus.pc_src;
    o.c.alu_src_b    = bus.alu_src_b;
    o.c.alu_op       = bus.alu_op;
    o.c.reg_we       = bus.reg_we;
    o.c.wb_sel       = bus.wb_sel;
    o.c.illegal_inst = bus.illegal_inst;
    o.c.mem_err      = bus.mem_err;
    return o;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got st=%0d ctrl=%h instret=%0d, want st=%0d ctrl=%h instret=%0d",
               name, got.st, got.c, got.ir, exp.st, exp.c, exp.ir);
    end
  endtask

  initial begin
    obs_t got, exp;
    bit   hit;
    bus.inst = I_R; bus.br_taken = 1'b0; bus.mem_ready = 1'b0;

    // Reset, R-type, LOAD with 3 wait cycles, BEQ taken/not taken, STORE.
    add(0, I_R, 0, 1, 0, C_NONE, 0);
    add(1, I_R, 0, 1, 0, C_NONE, 0);
    add(1, I_R, 0, 1, 1, C_FACK, 0);
    add(1, I_R, 0, 1, 2, C_NONE, 0);
    add(1, I_R, 0, 1, 3, C_EX_R, 0);
    add(1, I_R, 0, 1, 5, C_WB_ALU, 0);
    add(1, I_LD, 0, 1, 1, C_FACK, 1);
    add(1, I_LD, 0, 1, 2, C_NONE, 1);
    add(1, I_LD, 0, 1, 3, C_EX_LS, 1);
    for (int k = 0; k < 3; k++) add(1, I_LD, 0, 0, 4, C_MEM_LD, 1);
    add(1, I_LD, 0, 1, 4, C_MEM_LD, 1);
    add(1, I_LD, 0, 1, 5, C_WB_LD, 1);
    add(1, I_BEQ, 0, 1, 1, C_FACK, 2);
    add(1, I_BEQ, 1, 1, 2, C_NONE, 2);
    add(1, I_BEQ, 1, 1, 3, C_BR_T, 2);
    add(1, I_BEQ, 0, 1, 1, C_FACK, 3);
    add(1, I_BEQ, 0, 1, 2, C_NONE, 3);
    add(1, I_BEQ, 0, 1, 3, C_BR_N, 3);
    add(1, I_ST, 0, 1, 1, C_FACK, 4);
    add(1, I_ST, 0, 1, 2, C_NONE, 4);
    add(1, I_ST, 0, 1, 3, C_EX_LS, 4);
    add(1, I_ST, 0, 0, 4, C_MEM_ST, 4);
    add(1, I_ST, 0, 1, 4, C_ST_ACK, 4);
    add(1, I_BAD, 0, 1, 1, C_FACK, 5);
`ifdef ILLEGAL_TRAP_EN
    add(1, I_BAD, 0, 1, 2, C_NONE, 5);
    add(1, I_BAD, 1, 1, 7, C_TRAP, 5);
    add(1, I_BAD, 1, 0, 7, C_TRAP, 5);
`else
    add(1, I_BAD, 0, 1, 2, C_PC, 5);
    add(1, I_BAD, 0, 0, 1, C_FETCH, 5);
`endif
    // FETCH timeout after 4 low cycles; ERR is sticky.
    add(0, I_R, 0, 0, 0, C_NONE, 0);
    add(1, I_R, 0, 0, 0, C_NONE, 0);
    for (int k = 0; k < 4; k++) add(1, I_R, 0, 0, 1, C_FETCH, 0);
    add(1, I_R, 0, 1, 6, C_ERR, 0);
    add(1, I_R, 0, 1, 6, C_ERR, 0);
    // Ready on the last allowed cycle completes; then reset in the middle of a MEM wait.
    add(0, I_R, 0, 0, 0, C_NONE, 0);
    add(1, I_R, 0, 0, 0, C_NONE, 0);
    for (int k = 0; k < 3; k++) add(1, I_R, 0, 0, 1, C_FETCH, 0);
    add(1, I_R, 0, 1, 1, C_FACK, 0);
    add(1, I_R, 0, 1, 2, C_NONE, 0);
    add(1, I_R, 0, 1, 3, C_EX_R, 0);
    add(1, I_R, 0, 1, 5, C_WB_ALU, 0);
    add(1, I_LD, 0, 1, 1, C_FACK, 1);
    add(1, I_LD, 0, 1, 2, C_NONE, 1);
    add(1, I_LD, 0, 1, 3, C_EX_LS, 1);
    add(1, I_LD, 0, 0, 4, C_MEM_LD, 1);
    add(0, I_LD, 0, 0, 0, C_NONE, 0);
    // 16 retirements wrap the 4-bit counter, then a MEM timeout.
    add(1, I_R, 0, 1, 0, C_NONE, 0);
    for (int k = 0; k < 16; k++) begin
      logic [31:0] ins;
      ins = (k % 2 == 0) ? I_R : I_ADDI;
      add(1, ins, 0, 1, 1, C_FACK, 4'(k));
      add(1, ins, 0, 1, 2, C_NONE, 4'(k));
      add(1, ins, 0, 1, 3, (k % 2 == 0) ? C_EX_R : C_EX_I, 4'(k));
      add(1, ins, 0, 1, 5, C_WB_ALU, 4'(k));
    end
    add(1, I_LD, 0, 1, 1, C_FACK, 0);
    add(1, I_LD, 0, 1, 2, C_NONE, 0);
    add(1, I_LD, 0, 1, 3, C_EX_LS, 0);
    for (int k = 0; k < 4; k++) add(1, I_LD, 0, 0, 4, C_MEM_LD, 0);
    add(1, I_LD, 0, 1, 6, C_ERR, 0);

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      rst_n = tbl[i].rst; bus.inst = tbl[i].inst;
      bus.br_taken = tbl[i].br; bus.mem_ready = tbl[i].rdy;
      exp_q.push_back(tbl[i].exp);
      @(negedge clk);
      got = sample();
      exp = exp_q.pop_front();
      check($sformatf("vec%0d", i), got, exp);
    end

    // Hand-written: reset asserted between edges during a MEM wait drops mem_req at once.
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; bus.inst = I_ST; bus.mem_ready = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(posedge clk); #1;
      if (bus.state == 3'd4) hit = 1'b1;
    end
    bus.mem_ready = 1'b0;
    n_vec++;
    if (!hit) begin
      n_bad++;
      $display("FAIL reach_mem: got state=%0d, want 4 within 20 cycles", bus.state);
    end
    @(posedge clk); #2;
    check("mem_wait_hold", sample(), '{st: 3'd4, c: C_MEM_ST, ir: 4'd0});
    rst_n = 1'b0;
    #1;
    check("async_abort", sample(), '{st: 3'd0, c: C_NONE, ir: 4'd0});
    @(posedge clk); #1;
    check("abort_held", sample(), '{st: 3'd0, c: C_NONE, ir: 4'd0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control FSM for the RV32I core. It sequences fetch, decode, execute, memory and writeback, and drives the datapath selects around the immediate generator, ALU, register file and PC. It uses a req/ready handshake to a shared instruction/data memory port, with a timeout. It supports R, I-ALU, LOAD, STORE and BRANCH opcode classes.

Parameters:
MEM_WAIT_MAX, 16, max consecutive cycles with mem_ready low in FETCH/MEM before entering ERR (>=1)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
inst  in  32  current instruction register contents
br_taken  in  1  branch comparison result from ALU
mem_ready  in  1  memory ack, sampled only while mem_req=1
mem_req  out  1  memory request
mem_we  out  1  1=write (store)
mem_addr_sel  out  1  0=PC, 1=ALU result
ir_we  out  1  latch fetched word into IR
pc_we  out  1  PC write enable
pc_src  out  1  0=PC+4, 1=PC+imm
alu_src_b  out  1  0=rs2, 1=immediate
alu_op  out  2  00=add, 01=compare/sub, 10=funct3/funct7 decoded
reg_we  out  1  register file write enable
wb_sel  out  1  0=ALU, 1=memory data
illegal_inst  out  1  illegal opcode flag
mem_err  out  1  sticky memory timeout flag
state  out  3  current state (debug)
instret  out  CNT_W  retired-instruction count

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous, active-low rst_n. Reset forces state=IDLE, wait_cnt=0, instret=0. All outputs are 0 while reset is asserted and in IDLE.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERR=6, TRAP=7. Outputs are Moore-decoded from state, plus the decoded class and br_taken/mem_ready where noted.
- IDLE: stays one cycle, then goes to FETCH.
- FETCH: mem_req=1, mem_addr_sel=0, mem_we=0. ir_we=1 in the cycle mem_ready=1, then go to DECODE.
- DECODE: classify inst[6:0]:
  - 0110011 R, 0010011 I-ALU, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH: go to EXEC.
  - Any other opcode: illegal (see Optional Feature).
- EXEC:
  - R: alu_src_b=0, alu_op=10, go to WB.
  - I-ALU: alu_src_b=1, alu_op=10, go to WB.
  - LOAD/STORE: alu_src_b=1, alu_op=00, go to MEM.
  - BRANCH: alu_src_b=0, alu_op=01, pc_we=1, pc_src=br_taken, instret+1, go to FETCH.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=is_store, alu_src_b=1, alu_op=00 held.
  - On mem_ready, LOAD goes to WB.
  - On mem_ready, STORE asserts pc_we=1, pc_src=0, instret+1, then goes to FETCH.
- WB: reg_we=1, wb_sel=is_load, pc_we=1, pc_src=0, instret+1, go to FETCH. reg_we is asserted even when rd=x0; the register file discards that write.
- Handshake:
  - mem_req, mem_we and mem_addr_sel stay stable from assertion until mem_ready is sampled high.
  - A transfer completes on the edge where mem_req=1 and mem_ready=1.
  - mem_ready while mem_req=0 is ignored.
- Timeout:
  - wait_cnt clears on entry to FETCH and MEM, and increments each cycle mem_ready=0.
  - After MEM_WAIT_MAX consecutive low cycles, go to ERR.
  - mem_ready high in cycle MEM_WAIT_MAX completes normally.
- ERR: mem_err=1, all other control outputs 0. ERR is terminal until reset.
- instret wraps modulo 2^CNT_W.
- Reset mid-operation (e.g. during MEM wait) aborts immediately: mem_req drops asynchronously and no pc_we/reg_we is issued.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: illegal opcode in DECODE goes to TRAP. illegal_inst=1, all other control outputs 0, no PC update. TRAP is terminal until reset.
- Undefined: illegal opcode is treated as a NOP. DECODE asserts pc_we=1, pc_src=0, then goes to FETCH. instret is not incremented, illegal_inst is tied 0, and TRAP is unreachable.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state encoding constants
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH)
  - alu_op encodings (ALU_ADD, ALU_CMP, ALU_FUNCT)
  - instruction-class typedef
- One combinational sub-module, ctrl_decode: inst[6:0] in, one-hot class plus illegal out. The FSM, wait counter and instret stay in multicycle_ctrl.

Test Plan:
- Reset release, R-type 0x002081B3, mem_ready=1 immediately -> state 0,1,2,3,5,1; ir_we one cycle in FETCH; reg_we=1, wb_sel=0, pc_we=1 in WB; instret=1.
- LOAD 0x0080A283, mem_ready low 3 cycles in MEM -> mem_req=1, mem_addr_sel=1, mem_we=0 for 4 cycles; then WB with wb_sel=1, reg_we=1.
- BEQ 0x00208463: br_taken=1 -> EXEC pc_we=1, pc_src=1, reg_we=0, next FETCH. Repeat with br_taken=0 -> pc_src=0. instret +1 each time.
- STORE 0x0020A423 -> MEM mem_we=1; on ready pc_we=1, WB skipped, reg_we never 1.
- MEM_WAIT_MAX=4:
  - mem_ready held 0 in FETCH -> ERR after 4 cycles, mem_err=1, mem_req=0.
  - Separate run with ready on cycle 4 -> DECODE, no error.
  - rst_n low mid-MEM -> mem_req=0 same cycle, state=0.
- Opcode 0x0000007F:
  - ILLEGAL_TRAP_EN defined -> state=7, illegal_inst=1, outputs frozen.
  - Undefined -> single pc_we pulse, instret unchanged, next FETCH.
